// File: rtl/mult_pkg.sv
// Shared constants and types for the sequential Booth multiplier.
// The state encoding is fixed here so the FSM and any observers agree.
// prod_overflow is the 64-bit-to-32-bit sign-extension check on the final product.
package mult_pkg;

  localparam int WIDTH = 32;
  localparam int CNT_W = 5;
  localparam int P_W   = 2 * WIDTH + 2;
  localparam logic [CNT_W-1:0] LAST_STEP = 5'd31;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  // The product fits in 32 signed bits only if the high word is a pure sign extension of the low word.
  function automatic logic prod_overflow(input logic [WIDTH-1:0] h_lo, input logic [WIDTH-1:0] l);
    return h_lo != {WIDTH{l[WIDTH-1]}};
  endfunction

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth iteration on the partial product P = {H[32:0], L[31:0], q}.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to register the result.
module booth_step
  import mult_pkg::*;
(
  input  logic [P_W-1:0]   p_in,
  input  logic [WIDTH-1:0] m_in,
  output logic [P_W-1:0]   p_out
);

  logic [WIDTH:0] m_ext;
  logic [WIDTH:0] h_cur;
  logic [WIDTH:0] h_new;

  // Recode {L[0], q}, add or subtract M into the 33-bit H, then shift the whole P right arithmetically.
  always_comb begin
    m_ext = {m_in[WIDTH-1], m_in};
    h_cur = p_in[P_W-1:WIDTH+1];
    h_new = h_cur;
    case (p_in[1:0])
      2'b01:   h_new = h_cur + m_ext;
      2'b10:   h_new = h_cur - m_ext;
      default: h_new = h_cur;
    endcase
    p_out = {h_new[WIDTH], h_new, p_in[WIDTH:1]};
  end

endmodule

// File: rtl/booth_mult.sv
// Sequential 32x32 signed Booth multiplier: one add/sub + arithmetic shift per cycle.
// Latency: 33 edges from the start sample to the one-cycle result strobe; busy for 32 steps.
// Backpressure: none; a start pulse in any state aborts and restarts, the strobe is never held.
module booth_mult
  import mult_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_MULT,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [P_W-1:0]   p_q, p_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             exc_q, exc_d;
  logic [P_W-1:0]   p_step;

  booth_step u_step (
    .p_in  (p_q),
    .m_in  (m_q),
    .p_out (p_step)
  );

  // Next-state logic: a start wins from any state; otherwise step while running and latch the product on the last step.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    m_d     = m_q;
    res_d   = res_q;
    exc_d   = exc_q;
    if (ctrl_MULT) begin
      m_d     = data_operandA;
      p_d     = {{(WIDTH + 1){1'b0}}, data_operandB, 1'b0};
      cnt_d   = '0;
      state_d = RUN;
    end else begin
      case (state_q)
        RUN: begin
          p_d = p_step;
          if (cnt_q == LAST_STEP) begin
            // Counter parks at the last step; only a restart or reset clears it.
            state_d = DONE;
            res_d   = p_step[WIDTH:1];
            exc_d   = prod_overflow(p_step[2*WIDTH:WIDTH+1], p_step[WIDTH:1]);
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        DONE:    state_d = IDLE;
        IDLE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // All state, datapath and result registers; reset clears everything immediately.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      p_q     <= '0;
      m_q     <= '0;
      res_q   <= '0;
      exc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      m_q     <= m_d;
      res_q   <= res_d;
      exc_q   <= exc_d;
    end
  end

  assign data_result    = res_q;
  assign data_exception = exc_q;
  assign data_resultRDY = (state_q == DONE);
  assign busy           = (state_q == RUN);

endmodule
